// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit arbiter slice.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_e;

    // Default configuration
    localparam int UART_NUM_REQ_DEF   = 4;
    localparam int UART_DATA_BITS_DEF = 8;
    localparam int UART_TIMEOUT_DEF   = 64;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle of requester handshakes and transmitter pins around the UART arbiter.
// Latency: none (wires only).
// Backpressure: req_ready qualifies each requester's byte; tx_busy throttles the arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = UART_NUM_REQ_DEF,
    parameter int DATA_BITS = UART_DATA_BITS_DEF
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0][DATA_BITS-1:0] req_data;
    logic [NUM_REQ-1:0]                req_last;
    logic [NUM_REQ-1:0]                req_ready;
    logic [DATA_BITS-1:0]              tx_data;
    logic                              tx_send;
    logic                              tx_busy;
    logic [IW-1:0]                     grant_id;
    logic                              active;
    logic                              timeout_err;

    // Requesters plus transmitter side
    modport master (
        output req_valid, req_data, req_last, tx_busy,
        input  req_ready, tx_data, tx_send, grant_id, active, timeout_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_data, req_last, tx_busy,
        output req_ready, tx_data, tx_send, grant_id, active, timeout_err
    );
endinterface

// File: rtl/uart_rr_select.sv
// Round-robin picker: first set bit of mask_i searching upward from last_i+1, wrapping.
// Latency: combinational.
// Backpressure: none; any_o=0 when the mask is empty.
module uart_rr_select #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  mask_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o,
    output logic          any_o
);
    int k;

    // Walk N candidates starting just after the last grant; first hit wins
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        any_o    = 1'b0;
        k        = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last_i) + i) % N;
            if (!any_o && mask_i[k]) begin
                any_o       = 1'b1;
                index_o     = k[IW-1:0];
                onehot_o[k] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ requesters, round-robin with packet lock.
// Latency: accept to tx_send is 1 cycle; next accept only after tx_busy rises and falls.
// Backpressure: req_ready only in IDLE for the selected requester; optional busy timeout via UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = UART_NUM_REQ_DEF,
    parameter int DATA_BITS      = UART_DATA_BITS_DEF,
    parameter int TIMEOUT_CYCLES = UART_TIMEOUT_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE      = IDLE;
    localparam logic [1:0] ST_SEND      = SEND;
    localparam logic [1:0] ST_WAIT_BUSY = WAIT_BUSY;
    localparam logic [1:0] ST_WAIT_DONE = WAIT_DONE;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("uart_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic                 lock_q, lock_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    logic [NUM_REQ-1:0]   eligible;
    logic [NUM_REQ-1:0]   sel_onehot;
    logic [IW-1:0]        sel_idx;
    logic                 sel_any;
    logic                 to_fire;

    // A held packet lock narrows eligibility to the current owner only
    always_comb begin
        eligible = bus.req_valid;
        if (lock_q) begin
            eligible = bus.req_valid & (NUM_REQ'(1) << grant_q);
        end
    end

    uart_rr_select #(.N(NUM_REQ), .IW(IW)) u_sel (
        .mask_i   (eligible),
        .last_i   (grant_q),
        .onehot_o (sel_onehot),
        .index_o  (sel_idx),
        .any_o    (sel_any)
    );

    // Ready is gated by reset so it drops the instant reset asserts
    assign bus.req_ready = (state_q == ST_IDLE && sel_any && reset_n) ? sel_onehot : '0;
    assign bus.tx_data   = data_q;
    assign bus.tx_send   = (state_q == ST_SEND);
    assign bus.grant_id  = grant_q;
    assign bus.active    = (state_q != ST_IDLE);

    // FSM next state: accept in IDLE, pulse in SEND, then follow tx_busy up and down
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        lock_d  = lock_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_any) begin
                    state_d = ST_SEND;
                    grant_d = sel_idx;
                    data_d  = bus.req_data[sel_idx];
                    lock_d  = !bus.req_last[sel_idx];
                end
            end
            ST_SEND:      state_d = ST_WAIT_BUSY;
            ST_WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (to_fire) begin
                    state_d = ST_IDLE;
                    lock_d  = 1'b0;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default:      state_d = ST_IDLE;
        endcase
    end

    // Core registers; reset searches index 0 first by parking grant on the last index
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            grant_q <= IW'(NUM_REQ - 1);
            lock_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            lock_q  <= lock_d;
            data_q  <= data_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          to_err_q, to_err_d;

    assign to_fire = (state_q == ST_WAIT_BUSY) && !bus.tx_busy &&
                     (to_cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Count cycles spent waiting for busy; error flag is sticky until reset
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_WAIT_BUSY && !bus.tx_busy && !to_fire) begin
            to_cnt_d = to_cnt_q + CW'(1);
        end
        to_err_d = to_err_q | to_fire;
    end

    // Timeout registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_err_d;
        end
    end

    assign bus.timeout_err = to_err_q;
`else
    assign to_fire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural transmitter and arbitration model.
// Latency: expects tx_send one cycle after each accept.
// Backpressure: transmitter model holds tx_busy 1..4 cycles per byte, or never when tx_dead is set.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DB = 8;
    localparam int TO = 64;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_BITS(DB)) bus();

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .TIMEOUT_CYCLES(TO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Transmitter model: busy for a random 1..4 cycles after each start pulse
    int         busy_cnt = 0;
    bit         tx_dead  = 1'b0;
    logic [7:0] rx_q[$];
    always @(posedge clock) begin
        if (bus.tx_send === 1'b1 && !tx_dead) begin
            busy_cnt <= $urandom_range(1, 4);
            rx_q.push_back(bus.tx_data);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end
    assign bus.tx_busy = (busy_cnt != 0);

    // Requester byte queues ({last, data}), start delays, accept log, arbitration model
    logic [8:0] rq[NR][$];
    int         start_at[NR];
    int         acc_id[$];
    logic [7:0] acc_dat[$];
    int         m_grant = NR - 1;
    bit         m_lock  = 1'b0;

    function automatic int pending_bytes();
        int s = 0;
        for (int i = 0; i < NR; i++) s += rq[i].size();
        return s;
    endfunction

    // Owner if locked, else first valid index after the last grant
    function automatic int exp_sel(input logic [NR-1:0] v);
        if (m_lock) return v[m_grant] ? m_grant : -1;
        for (int k = 1; k <= NR; k++) begin
            if (v[(m_grant + k) % NR]) return (m_grant + k) % NR;
        end
        return -1;
    endfunction

    task automatic clear_all();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            start_at[i] = 0;
        end
        acc_id.delete();
        acc_dat.delete();
        rx_q.delete();
    endtask

    task automatic wait_tx_idle();
        for (int k = 0; k < 20 && busy_cnt != 0; k++) @(posedge clock);
        #1;
    endtask

    // Drive queued bytes and check every accept and start pulse against the model
    task automatic run_traffic(input int max_cyc, input bit stall);
        int            n        = 0;
        bit            due      = 1'b0;
        logic [7:0]    due_dat  = '0;
        int            last_snd = -100;
        int            e, idx;
        logic [NR-1:0] v, rdy, exp_rdy;
        while (n < max_cyc && (pending_bytes() > 0 || bus.active === 1'b1 || due)) begin
            for (int i = 0; i < NR; i++) begin
                v[i] = (rq[i].size() > 0) && (n >= start_at[i]) &&
                       !(stall && $urandom_range(0, 3) == 0);
                bus.req_data[i] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'($urandom);
                bus.req_last[i] = (rq[i].size() > 0) ? rq[i][0][8]   : 1'($urandom);
            end
            bus.req_valid = v;
            @(negedge clock);
            rdy = bus.req_ready;
            if (due || bus.tx_send === 1'b1) begin
                tests++;
                if (bus.tx_send !== 1'b1 || !due || bus.tx_data !== due_dat ||
                    bus.grant_id !== 2'(m_grant)) begin
                    fails++;
                    $display("FAIL send: tx_send=%b tx_data=%h grant_id=%0d, required tx_send=%b tx_data=%h grant_id=%0d",
                             bus.tx_send, bus.tx_data, bus.grant_id, due, due_dat, m_grant);
                end
                if (bus.tx_send === 1'b1) begin
                    tests++;
                    if (n - last_snd < 4) begin
                        fails++;
                        $display("FAIL spacing: %0d cycles between tx_send, required >= 4", n - last_snd);
                    end
                    last_snd = n;
                end
                due = 1'b0;
            end
            idx = -1;
            if (rdy !== '0) begin
                e       = exp_sel(v);
                exp_rdy = (e >= 0) ? NR'(1) << e : '0;
                tests++;
                if (rdy !== exp_rdy || bus.tx_busy === 1'b1 || bus.tx_send === 1'b1) begin
                    fails++;
                    $display("FAIL ready: req_ready=%b (busy=%b send=%b), required %b while idle",
                             rdy, bus.tx_busy, bus.tx_send, exp_rdy);
                end
                for (int i = NR - 1; i >= 0; i--) if (rdy[i] === 1'b1 && v[i]) idx = i;
                if (idx >= 0) begin
                    m_grant = idx;
                    m_lock  = !rq[idx][0][8];
                    due     = 1'b1;
                    due_dat = rq[idx][0][7:0];
                    acc_id.push_back(idx);
                    acc_dat.push_back(rq[idx][0][7:0]);
                end
            end
            @(posedge clock);
            #1;
            if (idx >= 0) void'(rq[idx].pop_front());
            n++;
        end
        bus.req_valid = '0;
        if (n >= max_cyc) begin
            tests++;
            fails++;
            $display("FAIL traffic_bound: %0d bytes left after %0d cycles, required 0", pending_bytes(), n);
        end
        wait_tx_idle();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #13;
        @(negedge clock);
        reset_n = 1'b1;
        m_grant = NR - 1;
        m_lock  = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bus.req_valid = '1;
        bus.req_data  = '0;
        bus.req_last  = '1;
        reset_n       = 1'b0;
        repeat (3) @(negedge clock);
        tests += 6;
        if (bus.req_ready !== '0)      begin fails++; $display("FAIL rst_ready: %b, required 0", bus.req_ready); end
        if (bus.tx_send !== 1'b0)      begin fails++; $display("FAIL rst_send: %b, required 0", bus.tx_send); end
        if (bus.tx_data !== 8'h00)     begin fails++; $display("FAIL rst_data: %h, required 00", bus.tx_data); end
        if (bus.grant_id !== 2'd3)     begin fails++; $display("FAIL rst_grant: %0d, required 3", bus.grant_id); end
        if (bus.active !== 1'b0)       begin fails++; $display("FAIL rst_active: %b, required 0", bus.active); end
        if (bus.timeout_err !== 1'b0)  begin fails++; $display("FAIL rst_timeout_err: %b, required 0", bus.timeout_err); end
        bus.req_valid = '0;
        reset_n       = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_round_robin();
        clear_all();
        for (int i = 0; i < NR; i++) begin
            rq[i].push_back({1'b1, 8'(8'hA0 + i)});
            rq[i].push_back({1'b1, 8'(8'hB0 + i)});
        end
        run_traffic(400, 1'b0);
        tests++;
        if (acc_id.size() != 8) begin
            fails++;
            $display("FAIL rr_count: %0d bytes, required 8", acc_id.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (acc_id[k] != k % 4 || acc_dat[k] !== 8'((k < 4 ? 8'hA0 : 8'hB0) + k % 4)) begin
                    fails++;
                    $display("FAIL rr_order: slot %0d id=%0d data=%h, required id=%0d", k, acc_id[k], acc_dat[k], k % 4);
                    break;
                end
            end
        end
    endtask

    task automatic test_single();
        clear_all();
        rq[0].push_back({1'b1, 8'h55});
        run_traffic(100, 1'b0);
        tests++;
        if (acc_id.size() != 1 || acc_id[0] != 0 || rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            fails++;
            $display("FAIL single: %0d accepts, %0d rx bytes, required one 0x55 from req 0", acc_id.size(), rx_q.size());
        end
    endtask

    task automatic test_packet_lock();
        logic [7:0] want[3];
        want = '{8'h11, 8'h22, 8'h33};
        clear_all();
        rq[2].push_back({1'b0, 8'h11});
        rq[2].push_back({1'b1, 8'h22});
        rq[1].push_back({1'b1, 8'h33});
        start_at[1] = 2;
        run_traffic(200, 1'b0);
        tests++;
        if (rx_q.size() != 3 || rx_q[0] !== want[0] || rx_q[1] !== want[1] || rx_q[2] !== want[2]) begin
            fails++;
            $display("FAIL lock_order: %0d bytes, first=%h, required 11 22 33", rx_q.size(),
                     rx_q.size() > 0 ? rx_q[0] : 8'h00);
        end
        // Owner goes quiet mid-packet: nobody else may be served
        clear_all();
        rq[3].push_back({1'b0, 8'h44});
        run_traffic(100, 1'b0);
        bus.req_valid = 4'b0011;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            tests++;
            if (bus.req_ready !== '0 || bus.active !== 1'b0) begin
                fails++;
                $display("FAIL lock_hold: req_ready=%b active=%b, required 0 and 0", bus.req_ready, bus.active);
            end
        end
        @(posedge clock);
        #1;
        clear_all();
        rq[3].push_back({1'b1, 8'h66});
        rq[0].push_back({1'b1, 8'h77});
        run_traffic(200, 1'b0);
        tests++;
        if (acc_id.size() != 2 || acc_id[0] != 3 || acc_id[1] != 0) begin
            fails++;
            $display("FAIL lock_resume: %0d accepts first id=%0d, required ids 3 then 0", acc_id.size(),
                     acc_id.size() > 0 ? acc_id[0] : -1);
        end
    endtask

    task automatic test_random();
        logic [7:0] exq[NR][$];
        int         j;
        bit         bad;
        for (int it = 0; it < 3; it++) begin
            clear_all();
            for (int i = 0; i < NR; i++) begin
                exq[i].delete();
                start_at[i] = $urandom_range(0, 10);
                for (int p = 0; p < $urandom_range(1, 4); p++) begin
                    int len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        logic [7:0] d = 8'($urandom);
                        rq[i].push_back({b == len - 1, d});
                        exq[i].push_back(d);
                    end
                end
            end
            run_traffic(4000, 1'b1);
            for (int i = 0; i < NR; i++) begin
                j   = 0;
                bad = 1'b0;
                for (int k = 0; k < acc_id.size(); k++) begin
                    if (acc_id[k] == i) begin
                        if (j >= exq[i].size() || acc_dat[k] !== exq[i][j]) bad = 1'b1;
                        j++;
                    end
                end
                tests++;
                if (bad || j != exq[i].size()) begin
                    fails++;
                    $display("FAIL rand_req%0d: iter %0d got %0d bytes, required %0d in order", i, it, j, exq[i].size());
                end
            end
            tests++;
            if (rx_q != acc_dat) begin
                fails++;
                $display("FAIL rand_rx: iter %0d rx %0d bytes, required %0d accepted bytes", it, rx_q.size(), acc_dat.size());
            end
        end
    endtask

    task automatic test_reset_mid_byte();
        int sends = 0;
        clear_all();
        bus.req_valid = 4'b0010;
        bus.req_data  = {8'h00, 8'h00, 8'h77, 8'h00};
        bus.req_last  = '1;
        for (int k = 0; k < 20 && bus.tx_busy !== 1'b1; k++) begin
            @(negedge clock);
            if (bus.req_ready[1] === 1'b1) begin
                @(posedge clock);
                #1;
                bus.req_valid = 4'b1000;
            end
        end
        tests++;
        if (bus.tx_busy !== 1'b1) begin
            fails++;
            $display("FAIL midbyte_busy: tx_busy=%b, required 1", bus.tx_busy);
        end
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        tests += 6;
        if (bus.req_ready !== '0)      begin fails++; $display("FAIL mid_ready: %b, required 0", bus.req_ready); end
        if (bus.tx_send !== 1'b0)      begin fails++; $display("FAIL mid_send: %b, required 0", bus.tx_send); end
        if (bus.tx_data !== 8'h00)     begin fails++; $display("FAIL mid_data: %h, required 00", bus.tx_data); end
        if (bus.grant_id !== 2'd3)     begin fails++; $display("FAIL mid_grant: %0d, required 3", bus.grant_id); end
        if (bus.active !== 1'b0)       begin fails++; $display("FAIL mid_active: %b, required 0", bus.active); end
        if (bus.timeout_err !== 1'b0)  begin fails++; $display("FAIL mid_timeout_err: %b, required 0", bus.timeout_err); end
        bus.req_valid = '0;
        #20;
        @(negedge clock);
        reset_n = 1'b1;
        m_grant = NR - 1;
        m_lock  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bus.tx_send === 1'b1) sends++;
        end
        tests++;
        if (sends != 0 || rx_q.size() != 1) begin
            fails++;
            $display("FAIL no_resend: %0d pulses after reset, %0d rx bytes, required 0 and 1", sends, rx_q.size());
        end
        wait_tx_idle();
    endtask

    task automatic test_timeout();
        int wb = 0;
        clear_all();
        tx_dead       = 1'b1;
        bus.req_valid = 4'b0001;
        bus.req_data  = {8'h00, 8'h00, 8'h00, 8'h5A};
        bus.req_last  = 4'b0000;
        for (int k = 0; k < 20 && bus.tx_send !== 1'b1; k++) @(negedge clock);
        bus.req_valid = '0;
`ifdef UART_ARB_TIMEOUT_EN
        for (int k = 0; k < 200; k++) begin
            @(negedge clock);
            if (bus.active !== 1'b1) break;
            wb++;
        end
        tests += 2;
        if (wb != TO) begin
            fails++;
            $display("FAIL timeout_len: %0d wait cycles, required %0d", wb, TO);
        end
        if (bus.timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_flag: %b, required 1", bus.timeout_err);
        end
        tx_dead = 1'b0;
        m_grant = 0;
        m_lock  = 1'b0;
        @(posedge clock);
        #1;
        rq[1].push_back({1'b1, 8'h31});
        run_traffic(100, 1'b0);
        tests += 2;
        if (acc_id.size() != 1 || acc_id[0] != 1) begin
            fails++;
            $display("FAIL timeout_unlock: %0d accepts, required req 1 served", acc_id.size());
        end
        if (bus.timeout_err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: %b, required 1", bus.timeout_err);
        end
        apply_reset();
        clear_all();
        for (int i = 0; i < NR; i++) rq[i].push_back({1'b1, 8'(8'hC0 + i)});
        run_traffic(200, 1'b0);
        tests++;
        if (bus.timeout_err !== 1'b0 || acc_id.size() != NR) begin
            fails++;
            $display("FAIL timeout_normal: timeout_err=%b accepts=%0d, required 0 and %0d", bus.timeout_err, acc_id.size(), NR);
        end
`else
        repeat (150) @(negedge clock);
        wb = 150;
        tests++;
        if (bus.active !== 1'b1 || bus.timeout_err !== 1'b0) begin
            fails++;
            $display("FAIL no_timeout: active=%b timeout_err=%b after %0d cycles, required 1 and 0",
                     bus.active, bus.timeout_err, wb);
        end
        tx_dead = 1'b0;
        apply_reset();
`endif
        tx_dead = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_packet_lock();
        test_random();
        test_reset_mid_byte();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
